// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed BCD to seven-segment scan driver with blink modes,
// leading-zero blanking, per-digit decimal points and invalid-digit dash.
module seven_seg_scan_driver #(
   parameter int NUM_DIGITS     = 4,
   parameter int SCAN_DIV       = 100000,
   parameter int BLINK_DIV      = 50000000,
   parameter bit SEG_ACTIVE_LOW = 1'b0,
   parameter bit EN_ACTIVE_LOW  = 1'b0
) (
   input  logic                    Clk,
   input  logic                    Reset,
   input  logic [4*NUM_DIGITS-1:0] BcdIn,
   input  logic [NUM_DIGITS-1:0]   DpIn,
   input  logic [1:0]              Mode,
   input  logic                    LzbEn,
   output logic [6:0]              Seg,
   output logic                    Dp,
   output logic [NUM_DIGITS-1:0]   DigitEn,
   output logic                    BlinkPhase
);

   localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int SCAN_W  = $clog2(SCAN_DIV);
   localparam int BLINK_W = $clog2(BLINK_DIV);
   localparam logic [6:0]            SEG_INV = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic                  DP_INV  = SEG_ACTIVE_LOW;
   localparam logic [NUM_DIGITS-1:0] EN_INV  = EN_ACTIVE_LOW ? '1 : '0;

   typedef enum logic [1:0] {STEADY, BLINK_ON, BLINK_OFF} blinkState_t;

   function automatic logic [6:0] decodeBcd(input logic [3:0] bcd);
      case (bcd)
         4'd0:    return 7'b0111111;
         4'd1:    return 7'b0000110;
         4'd2:    return 7'b1011011;
         4'd3:    return 7'b1001111;
         4'd4:    return 7'b1100110;
         4'd5:    return 7'b1101101;
         4'd6:    return 7'b1111101;
         4'd7:    return 7'b0000111;
         4'd8:    return 7'b1111111;
         4'd9:    return 7'b1101111;
         default: return 7'b1000000;
      endcase
   endfunction

   logic [SCAN_W-1:0]  scanCnt;
   logic [IDX_W-1:0]   digitIdx;
   logic               scanTick;
   blinkState_t        state, stateNext;
   logic [BLINK_W-1:0] blinkCnt, blinkCntNext, halfLast;
   logic [1:0]         prevMode;
   logic [6:0]         segNext;
   logic               dpNext;
   logic [NUM_DIGITS-1:0] enNext;
   logic               allZero, blank, visible;

   assign scanTick = (scanCnt == SCAN_W'(SCAN_DIV - 1));

   // The index names the digit shown in the slot that starts at the next tick.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         scanCnt  <= '0;
         digitIdx <= IDX_W'(NUM_DIGITS - 1);
      end else if (scanTick) begin
         scanCnt  <= '0;
         digitIdx <= (digitIdx == '0) ? IDX_W'(NUM_DIGITS - 1) : digitIdx - IDX_W'(1);
      end else begin
         scanCnt <= scanCnt + SCAN_W'(1);
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state      <= STEADY;
         blinkCnt   <= '0;
         prevMode   <= 2'd1;
         BlinkPhase <= 1'b1;
      end else begin
         state      <= stateNext;
         blinkCnt   <= blinkCntNext;
         prevMode   <= Mode;
         BlinkPhase <= (stateNext != BLINK_OFF);
      end
   end

   always_comb begin
      halfLast     = (Mode == 2'd2) ? BLINK_W'(BLINK_DIV - 1) : BLINK_W'(BLINK_DIV / 2 - 1);
      stateNext    = state;
      blinkCntNext = blinkCnt + BLINK_W'(1);
      if (Mode < 2'd2) begin
         stateNext    = STEADY;
         blinkCntNext = '0;
      end else if (Mode != prevMode || state == STEADY) begin
         stateNext    = BLINK_ON;
         blinkCntNext = '0;
      end else if (blinkCnt == halfLast) begin
         stateNext    = (state == BLINK_ON) ? BLINK_OFF : BLINK_ON;
         blinkCntNext = '0;
      end
   end

   // Walk from the top digit down so allZero covers every nibble above and at i.
   always_comb begin
      segNext = '0;
      dpNext  = 1'b0;
      enNext  = '0;
      allZero = 1'b1;
      blank   = 1'b0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         allZero = allZero && (BcdIn[4*i +: 4] == 4'd0);
         if (digitIdx == IDX_W'(i)) begin
            blank     = LzbEn && allZero && (i != 0);
            segNext   = blank ? 7'd0 : decodeBcd(BcdIn[4*i +: 4]);
            dpNext    = DpIn[i];
            enNext[i] = 1'b1;
         end
      end
      visible = (Mode != 2'd0) && BlinkPhase;
      if (!visible) begin
         segNext = '0;
         dpNext  = 1'b0;
         enNext  = '0;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         Seg     <= SEG_INV;
         Dp      <= DP_INV;
         DigitEn <= EN_INV;
      end else if (scanTick) begin
         Seg     <= segNext ^ SEG_INV;
         Dp      <= dpNext ^ DP_INV;
         DigitEn <= enNext ^ EN_INV;
      end
   end

endmodule

// File: doc/seven_seg_scan_driver.md
Name: seven_seg_scan_driver

Overview:
Parametrised, time-multiplexed BCD-to-seven-segment driver for an N-digit common-anode/cathode display. It scans one digit per slot from a single system clock, supports steady, slow-blink and fast-blink display modes, leading-zero blanking, per-digit decimal points and an invalid-digit dash. It sits between the binary-to-BCD converter and the board display pins, replacing the fixed 4-digit driver that ran from separate 1 Hz and 8 ms clocks.

Parameters:
NUM_DIGITS, 4, number of display digits (1..8).
SCAN_DIV, 100000, clock cycles per digit slot (>=2).
BLINK_DIV, 50000000, clock cycles per half-period in slow blink (even, >=4).
SEG_ACTIVE_LOW, 0, 1 = segment and DP outputs driven low-true.
EN_ACTIVE_LOW, 0, 1 = digit enables driven low-true.

Ports:
Clk  in  1  system clock, all logic rising-edge.
Reset  in  1  asynchronous, active-high reset.
BcdIn  in  4*NUM_DIGITS  packed BCD; nibble i = digit i (digit 0 least significant).
DpIn  in  NUM_DIGITS  decimal point request per digit.
Mode  in  2  0 off, 1 steady, 2 slow blink, 3 fast blink.
LzbEn  in  1  leading-zero blanking enable.
Seg  out  7  segments, bit0=A ... bit6=G, registered.
Dp  out  1  decimal point, registered.
DigitEn  out  NUM_DIGITS  one-hot digit enable, bit i = digit i, registered.
BlinkPhase  out  1  current blink phase (1 = visible), registered.

Behaviour:
- Reset (async assert, sync-safe release): scan counter 0, digit index NUM_DIGITS-1, blink counter 0, BlinkPhase 1, previous-mode register 1, Seg/Dp/DigitEn all at inactive level (0 when active-high, all ones when active-low).
- Scan counter counts 0..SCAN_DIV-1 and wraps; on the wrap cycle (scan tick) digit index decrements, NUM_DIGITS-1 down to 0, then wraps to NUM_DIGITS-1.
- Seg/Dp/DigitEn are loaded on every scan tick from the new index and the current BcdIn/DpIn/Mode/LzbEn. Latency is exactly one clock from the tick cycle. Outputs hold between ticks, so input changes mid-slot appear at the next slot.
- Decode (active-high): 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111. Nibble values 10..15 give a dash: 1000000.
- Leading-zero blanking: when LzbEn=1, digit i is blank (Seg inactive, DigitEn still asserted) if every nibble from NUM_DIGITS-1 down to i is 0 and i != 0. Digit 0 is never blanked. Dp follows DpIn[i] even on a blanked digit.
- Blink FSM states: STEADY, BLINK_ON, BLINK_OFF.
  - Half-period is BLINK_DIV cycles for Mode 2 and BLINK_DIV/2 for Mode 3.
  - The blink counter counts to half-period-1, then toggles between BLINK_ON and BLINK_OFF and clears.
  - Mode 0/1 force STEADY with BlinkPhase=1 and the counter held at 0.
- Any change of Mode (compared against the registered previous value) clears the blink counter and enters BLINK_ON (or STEADY) on the next cycle. The new half-period applies from that point.
- Display gate is evaluated at load time. If Mode=0 or BlinkPhase=0, the loaded DigitEn, Seg and Dp are all inactive. Scanning and the index continue regardless, so the rhythm is preserved on return.
- If a scan tick and a blink toggle fall on the same cycle, the load uses the pre-toggle BlinkPhase. The gate takes effect on the following tick.
- Polarity parameters invert only the final registered outputs. Internal logic is always active-high.
- Reset asserted mid-scan or mid-blink returns immediately to the reset values. There is no partial-frame output.

Test Plan:
- NUM_DIGITS=4, SCAN_DIV=4, Mode=1, BcdIn=16'h1234: after reset, DigitEn sequence 1000,0100,0010,0001 repeating every 4 clocks. Seg = 0000110, 1011011, 1001111, 1100110 in step with DigitEn, each one clock after its tick.
- BcdIn=16'h0050, LzbEn=1: digits 3 and 2 have DigitEn asserted with Seg=0. Digit 1 shows 1101101, digit 0 shows 0111111. With LzbEn=0, digits 3 and 2 show 0111111.
- BcdIn=16'h9A0F, DpIn=4'b0100: digit 3=1101111, digit 2=1000000 with Dp=1, digit 1=0111111, digit 0=1000000.
- BLINK_DIV=16, Mode=2: BlinkPhase toggles every 16 clocks and DigitEn is all-zero during off phases. Switching to Mode=3 mid-phase restarts at BlinkPhase=1 with 8-clock half-periods.
- Mode=0: DigitEn/Seg/Dp stay inactive while the scan index keeps cycling. Returning to Mode=1 resumes from the current index at the next tick.
- SEG_ACTIVE_LOW=1, EN_ACTIVE_LOW=1: assert Reset mid-frame and check all outputs go to ones asynchronously. After release, the first load (digit 3) appears 4 clocks later, bit-inverted.
